// File: rtl/vigna_clint.sv
// rtl/vigna_clint.sv - core-local timer/software interrupt block (mtime, mtimecmp, msip).
// Optional: define VIGNA_CLINT_MTIME_WR_EN to make mtime writable from the bus.
module vigna_clint #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [4:0]  s_addr,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic [31:0] s_rdata,
    output logic        timer_irq,
    output logic        soft_irq
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    localparam logic [2:0] SEL_MSIP   = 3'd0;
    localparam logic [2:0] SEL_CMP_LO = 3'd2;
    localparam logic [2:0] SEL_CMP_HI = 3'd3;
    localparam logic [2:0] SEL_MT_LO  = 3'd4;
    localparam logic [2:0] SEL_MT_HI  = 3'd5;

    logic        ready_q;
    logic [31:0] rdata_q, rdata_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic [15:0] presc_q, presc_d;
    logic        timer_irq_q, soft_irq_q;

    logic        exec;
    logic        wr;
    logic [2:0]  sel;
    logic        tick;
    logic [63:0] mtime_inc;
    logic        unused_addr;

    assign unused_addr = ^s_addr[1:0];

    // An access executes only on the first cycle of s_valid; the held request is not re-run.
    assign exec = s_valid && !ready_q;
    assign wr   = exec && (s_wstrb != 4'b0000);
    assign sel  = s_addr[4:2];

    assign tick      = (presc_q == TICK_LAST);
    assign presc_d   = tick ? 16'd0 : presc_q + 16'd1;
    assign mtime_inc = mtime_q + {63'd0, tick};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        mtime_d    = mtime_inc;
        if (wr) begin
            case (sel)
                SEL_MSIP: begin
                    if (s_wstrb[0]) begin
                        msip_d = s_wdata[0];
                    end
                end
                SEL_CMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], s_wdata, s_wstrb);
                SEL_CMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], s_wdata, s_wstrb);
`ifdef VIGNA_CLINT_MTIME_WR_EN
                // Unwritten bytes keep the ticked value; a lo write never carries into hi.
                SEL_MT_LO:  mtime_d[31:0]  = merge_bytes(mtime_inc[31:0], s_wdata, s_wstrb);
                SEL_MT_HI:  mtime_d[63:32] = merge_bytes(mtime_inc[63:32], s_wdata, s_wstrb);
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (exec) begin
            case (sel)
                SEL_MSIP:   rdata_d = {31'd0, msip_q};
                SEL_CMP_LO: rdata_d = mtimecmp_q[31:0];
                SEL_CMP_HI: rdata_d = mtimecmp_q[63:32];
                SEL_MT_LO:  rdata_d = mtime_q[31:0];
                SEL_MT_HI:  rdata_d = mtime_q[63:32];
                default:    rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q     <= 1'b0;
            rdata_q     <= 32'd0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q      <= 1'b0;
            presc_q     <= 16'd0;
            timer_irq_q <= 1'b0;
            soft_irq_q  <= 1'b0;
        end else begin
            ready_q     <= s_valid;
            rdata_q     <= rdata_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            presc_q     <= presc_d;
            // Compare uses pre-edge values, giving one cycle of latency after any change.
            timer_irq_q <= (mtime_q >= mtimecmp_q);
            soft_irq_q  <= msip_q;
        end
    end

    assign s_ready   = ready_q;
    assign s_rdata   = rdata_q;
    assign timer_irq = timer_irq_q;
    assign soft_irq  = soft_irq_q;

endmodule
